axi_ame_wr_engine: RTL
======================

// Module: axi_ame_wr_engine
// PURPOSE
// - Parametrised AXI4 master write-burst engine; successor to the fixed 32-bit AME write path.
// - Accepts one descriptor (base addr, beat count) plus a beat stream.
// - Splits the transfer into INCR bursts of <= MAX_BURST beats that never cross a 4 KiB boundary.
// - Keeps up to MAX_OUTSTANDING bursts awaiting B; reports run/done/error.
// - Sits between the AME control regs (AXI-lite side) and the memory interconnect.
// PARAMETERS
// ADDR_WIDTH       32   AXI address width
// DATA_WIDTH       32   AXI data width; power of 2, 32..512
// LEN_WIDTH        24   width of descriptor beat count
// MAX_BURST        16   max beats per burst; power of 2, 1..256
// MAX_OUTSTANDING  4    max bursts with AW done and B pending; >= 1
// PORTS
// m_axi_aclk     in   1           single clock for all logic
// m_axi_areset   in   1           asynchronous reset, active-high
// cmd_addr       in   ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits ignored
// cmd_len        in   LEN_WIDTH   transfer length in beats
// cmd_valid/ready in/out 1        descriptor handshake; ready only in IDLE
// s_data         in   DATA_WIDTH  write beat
// s_valid/ready  in/out 1         beat handshake
// m_axi_aw*      out/in           awaddr, awlen[7:0], awsize[2:0], awburst[1:0], awlock, awcache[3:0], awprot[2:0], awqos[3:0], awvalid / awready
// m_axi_w*       out/in           wdata[DATA_WIDTH], wstrb[DATA_WIDTH/8], wlast, wvalid / wready
// m_axi_b*       in/out           bresp[1:0], bvalid / bready
// ame_run        out  1           high from cmd accept until done
// ame_done       out  1           1-cycle pulse at completion
// ame_error      out  1           sticky; any bresp[1]=1 or unexpected B; cleared on next cmd accept
// BEHAVIOUR
// - Reset values:
//   - all valid outputs 0; ame_run/done/error 0; cmd_ready 1; bready 1; counters 0; state IDLE.
// - Constant fields:
//   - awsize = log2(DATA_WIDTH/8); awburst = 2'b01 (INCR); awcache = 4'b0011.
//   - awlock, awprot, awqos = 0; wstrb all ones.
// - FSM:
//   - IDLE --cmd hs--> CALC (len=0: -> IDLE with ame_done pulse next cycle, no AXI traffic).
//   - CALC: beats = min(remaining, MAX_BURST, (4096 - addr[11:0]) / bytes_per_beat).
//     - Registered result; stays in CALC while outstanding == MAX_OUTSTANDING.
//     - Otherwise -> AW.
//   - AW: awvalid held with stable addr/len until awready; awlen = beats-1; -> DATA.
//   - DATA: wvalid = s_valid, s_ready = wready, wdata = s_data.
//     - wlast on beat==beats-1; after the last hs: addr += beats*bytes, remaining -= beats.
//     - remaining != 0 -> CALC; remaining == 0 -> WAIT_B.
//   - WAIT_B: outstanding == 0 -> IDLE, ame_done = 1 for exactly one cycle, ame_run falls in the same cycle.
// - Outstanding counter:
//   - +1 on AW hs, -1 on B hs.
//   - Simultaneous AW hs and B hs: count unchanged.
//   - B with count == 0: ignored for counting, sets ame_error.
// - Latency: cmd hs -> first awvalid = 2 cycles (CALC registered); back-to-back bursts have 1 CALC cycle gap.
// - Zero-wait beats stream 1 per cycle within a burst; no W before its AW is issued.
// - bresp SLVERR/DECERR sets ame_error; transfer still completes normally.
// - ame_error clears on the next cmd accept.
// - Address arithmetic is modulo 2^ADDR_WIDTH; 4 KiB split makes wrap impossible within a burst.
// - Reset mid-operation: immediate return to reset values; in-flight AXI bursts abandoned.
//   Interconnect reset is the integrator's responsibility.
// STRUCTURE
// - Package axi_ame_pkg:
//   - state_t enum {IDLE, CALC, AW, DATA, WAIT_B}.
//   - AXI_BURST_INCR, AXI_CACHE_BUF_MOD, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
//   - function clog2-based awsize helper.
// - Sub-module axi_ame_burst_calc: registered min(remaining, MAX_BURST, 4 KiB distance); reused by the future read engine.
// - Top holds FSM, address/remaining regs, beat counter, outstanding counter.
// TESTING
// 1. addr=0x1000, len=40, MAX_BURST=16, B OKAY -> 3 AWs: (0x1000,len15), (0x1040,len15), (0x1080,len7); 40 W beats; wlast on beats 16/32/40; done pulse once; error=0.
// 2. addr=0x1FF8, len=8, DATA_WIDTH=32 -> AW (0x1FF8,len1) then (0x2000,len5); no burst crosses 0x2000.
// 3. MAX_OUTSTANDING=2, bvalid held low, len=64 -> exactly 2 AWs; engine parks in CALC; releasing B resumes; done only after 4th B.
// 4. 2nd burst returns bresp=2'b10 -> ame_error=1 sticky through done; next cmd accept clears it.
// 5. len=0 -> no awvalid/wvalid ever; ame_done pulses 1 cycle after cmd hs.
// 6. m_axi_areset asserted during DATA beat 5 -> all outputs at reset values in the same cycle; next cmd of len=4 completes cleanly.

Source files
------------

// File: rtl/axi_ame_pkg.sv
// Shared types and AXI constants for the AME write engine and its future read twin.
package axi_ame_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    AW     = 3'd2,
    DATA   = 3'd3,
    WAIT_B = 3'd4
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY   = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR   = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR   = 2'b11;

  // Beat counts up to 256 need nine bits.
  localparam int BEATS_W = 9;

  function automatic logic [2:0] axi_size(input int data_width);
    int sz;
    sz = $clog2(data_width / 8);
    return sz[2:0];
  endfunction

endpackage

// File: rtl/axi_ame_burst_calc.sv
// Registered burst sizing: min(remaining beats, MAX_BURST, beats left before the next 4 KiB page).
module axi_ame_burst_calc
  import axi_ame_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 24,
  parameter int MAX_BURST  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 calc_en_i,
  input  logic [LEN_WIDTH-1:0] remaining_i,
  input  logic [11:0]          addr_lo_i,
  output logic [BEATS_W-1:0]   beats_o
);

  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  localparam int CW   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [12:0]        dist_bytes;
  logic [CW-1:0]      dist_c;
  logic [CW-1:0]      rem_c;
  logic [CW-1:0]      lim_c;
  logic [CW-1:0]      min_c;
  logic [BEATS_W-1:0] beats_d;
  logic [BEATS_W-1:0] beats_q;

  always_comb begin
    dist_bytes = 13'h1000 - {1'b0, addr_lo_i};
    dist_c     = CW'(dist_bytes >> SIZE);
    rem_c      = CW'(remaining_i);
    lim_c      = CW'(MAX_BURST);
    min_c      = (rem_c < lim_c) ? rem_c : lim_c;
    if (dist_c < min_c) min_c = dist_c;
    beats_d    = min_c[BEATS_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            beats_q <= '0;
    else if (calc_en_i) beats_q <= beats_d;
  end

  assign beats_o = beats_q;

endmodule

// File: rtl/axi_ame_wr_engine.sv
// AXI4 write-burst master: splits one descriptor into 4 KiB-safe INCR bursts and tracks B responses.
module axi_ame_wr_engine
  import axi_ame_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int LEN_WIDTH       = 24,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_areset,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic [3:0]              m_axi_awqos,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    ame_run,
  output logic                    ame_done,
  output logic                    ame_error
);

  localparam int SIZE = $clog2(DATA_WIDTH / 8);
  localparam int OW   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((DATA_WIDTH / 8) - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [BEATS_W-1:0]    beat_q, beat_d;
  logic [OW-1:0]         out_q, out_d;
  logic                  run_q, run_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [BEATS_W-1:0]    beats;
  logic [BEATS_W-1:0]    beats_m1;
  logic [LEN_WIDTH-1:0]  rem_after;
  logic                  cmd_hs, aw_hs, w_hs, b_hs, last_beat;

  axi_ame_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) u_calc (
    .clk         (m_axi_aclk),
    .rst         (m_axi_areset),
    .calc_en_i   (state_q == CALC),
    .remaining_i (rem_q),
    .addr_lo_i   (addr_q[11:0]),
    .beats_o     (beats)
  );

  assign beats_m1  = beats - BEATS_W'(1);
  assign last_beat = (beat_q == beats_m1);
  assign rem_after = rem_q - LEN_WIDTH'(beats);
  assign cmd_hs    = cmd_valid & cmd_ready;
  assign aw_hs     = m_axi_awvalid & m_axi_awready;
  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      beat_q  <= '0;
      out_q   <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_hs && (cmd_len != '0)) state_d = CALC;
      CALC:    if (out_q != OW'(MAX_OUTSTANDING)) state_d = AW;
      AW:      if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && last_beat) state_d = (rem_after != '0) ? CALC : WAIT_B;
      WAIT_B:  if (out_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status registers follow the FSM decisions.
  always_comb begin
    addr_d = addr_q;
    rem_d  = rem_q;
    beat_d = beat_q;
    run_d  = run_q;
    done_d = 1'b0;
    err_d  = err_q;
    if (cmd_hs) begin
      addr_d = cmd_addr & ALIGN_MASK;
      rem_d  = cmd_len;
      beat_d = '0;
      run_d  = (cmd_len != '0);
      done_d = (cmd_len == '0);
      err_d  = 1'b0;
    end
    if ((state_q == DATA) && w_hs) begin
      if (last_beat) begin
        beat_d = '0;
        addr_d = addr_q + (ADDR_WIDTH'(beats) << SIZE);
        rem_d  = rem_after;
      end else begin
        beat_d = beat_q + BEATS_W'(1);
      end
    end
    if ((state_q == WAIT_B) && (out_q == '0)) begin
      run_d  = 1'b0;
      done_d = 1'b1;
    end
    // A B with nothing outstanding is a protocol error but must not underflow the count.
    if (b_hs && ((m_axi_bresp == AXI_RESP_SLVERR) || (m_axi_bresp == AXI_RESP_DECERR)
                 || (out_q == '0)))
      err_d = 1'b1;
  end

  always_comb begin
    out_d = out_q;
    unique case ({aw_hs, b_hs && (out_q != '0)})
      2'b10:   out_d = out_q + OW'(1);
      2'b01:   out_d = out_q - OW'(1);
      default: out_d = out_q;
    endcase
  end

  always_comb begin
    cmd_ready     = (state_q == IDLE);
    m_axi_awvalid = (state_q == AW);
    m_axi_wvalid  = (state_q == DATA) && s_valid;
    s_ready       = (state_q == DATA) && m_axi_wready;
    m_axi_wlast   = (state_q == DATA) && last_beat;
  end

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = beats_m1[7:0];
  assign m_axi_awsize  = axi_size(DATA_WIDTH);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_BUF_MOD;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = 1'b1;
  assign ame_run       = run_q;
  assign ame_done      = done_q;
  assign ame_error     = err_q;

endmodule
